// File: rtl/udlx_pkg.sv
// Shared constants and types for the udlx fetch/decode pipeline.
package udlx_pkg;

  localparam int PC_DATA_WIDTH     = 20;
  localparam int INSTRUCTION_WIDTH = 32;

  // Word injected into the pipeline for bubbles (flush, boot, reset).
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0;

  // Byte distance between consecutive instruction words.
  localparam int PC_INCREMENT = 4;

  // Hold FSM: RUN passes SRAM data straight through, HOLD replays the
  // word captured when the stall began.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side and decode-side signals of the IF/ID pipeline register.
// The master drives control, fetch PC and SRAM data; the slave (the stage)
// drives the registered pipeline outputs.
interface if_id_stage_if #(
  parameter int PC_DATA_WIDTH     = 20,
  parameter int INSTRUCTION_WIDTH = 32
) ();

  logic                         stall;
  logic                         flush;
  logic                         boot_mode;
  logic [PC_DATA_WIDTH-1:0]     pc_in;
  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in;

  logic [PC_DATA_WIDTH-1:0]     pc_out;
  logic [PC_DATA_WIDTH-1:0]     new_pc_out;
  logic [INSTRUCTION_WIDTH-1:0] instruction_reg_out;
  logic                         valid_out;

  modport master (
    output stall, flush, boot_mode, pc_in, inst_mem_data_in,
    input  pc_out, new_pc_out, instruction_reg_out, valid_out
  );

  modport slave (
    input  stall, flush, boot_mode, pc_in, inst_mem_data_in,
    output pc_out, new_pc_out, instruction_reg_out, valid_out
  );

endinterface

// File: rtl/if_id_stage_fetch_hold_buffer.sv
// Keeps the SRAM word belonging to the in-flight request alive across a
// stall. The SRAM keeps reading the (frozen) next fetch address while
// stalled, so its output drifts to the following word; this buffer
// captures the correct word on the first stalled edge and replays it.
module fetch_hold_buffer
  import udlx_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         kill,      // flush or boot_mode
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
  output logic [INSTRUCTION_WIDTH-1:0] sel_data
);

  hold_state_e                  state;
  logic [INSTRUCTION_WIDTH-1:0] hold_data;
  logic                         enter_hold;

  assign enter_hold = (state == RUN) && stall && !kill;

  // Hold FSM: kill always returns to RUN, otherwise follow stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else if (kill) begin
      state <= RUN;
    end else if (enter_hold) begin
      // NOTE: sequential state uses <= so every register samples the
      // pre-edge values of its inputs, regardless of statement order.
      state <= HOLD;
    end else if (!stall) begin
      state <= RUN;
    end
  end

  // Capture the word for the stalled request on the RUN->HOLD edge only.
  // NOTE: hold_data has no reset on purpose; it is read only in HOLD, and
  // HOLD is reachable only through an edge that loads it first.
  always_ff @(posedge clk) begin
    if (enter_hold) begin
      hold_data <= mem_data;
    end
  end

  assign sel_data = (state == HOLD) ? hold_data : mem_data;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register. Pairs each fetch PC with the synchronous SRAM
// word that returns a cycle later, freezes on stall, and inserts bubbles
// on flush or while the boot loader is active.
module if_id_stage #(
  parameter int                           PC_DATA_WIDTH     = udlx_pkg::PC_DATA_WIDTH,
  parameter int                           INSTRUCTION_WIDTH = udlx_pkg::INSTRUCTION_WIDTH,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   =
    INSTRUCTION_WIDTH'(udlx_pkg::NOP_INSTRUCTION)
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  logic                         kill;
  logic [PC_DATA_WIDTH-1:0]     req_pc;
  logic                         req_valid;
  logic [INSTRUCTION_WIDTH-1:0] sel_data;

  logic [PC_DATA_WIDTH-1:0]     pc_q;
  logic [PC_DATA_WIDTH-1:0]     new_pc_q;
  logic [INSTRUCTION_WIDTH-1:0] inst_q;
  logic                         valid_q;

  // Boot loader activity is handled exactly like a flush, every cycle.
  assign kill = bus.flush || bus.boot_mode;

  // Request register: mirrors the SRAM read currently in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc    <= '0;
      req_valid <= 1'b0;
    end else begin
      if (!bus.stall) begin
        req_pc    <= bus.pc_in;
        req_valid <= !kill;
      end else if (kill) begin
        req_valid <= 1'b0;
      end
    end
  end

  fetch_hold_buffer #(
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall),
    .kill     (kill),
    .mem_data (bus.inst_mem_data_in),
    .sel_data (sel_data)
  );

  // Output register: advance when unstalled, bubble on flush/boot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      new_pc_q <= '0;
      inst_q   <= NOP_INSTRUCTION;
      valid_q  <= 1'b0;
    end else if (kill || !bus.stall) begin
      pc_q     <= req_pc;
      new_pc_q <= req_pc + PC_DATA_WIDTH'(udlx_pkg::PC_INCREMENT);
      inst_q   <= kill ? NOP_INSTRUCTION :
                  (req_valid ? sel_data : NOP_INSTRUCTION);
      valid_q  <= !kill && req_valid;
    end
  end

  assign bus.pc_out              = pc_q;
  assign bus.new_pc_out          = new_pc_q;
  assign bus.instruction_reg_out = inst_q;
  assign bus.valid_out           = valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, a reset-during-stall
// sequence, and a randomized run against a reference model that states
// the stage's contract directly (a valid output carries the SRAM word of
// its own PC).
module tb_if_id_stage;

  localparam int PW = 20;
  localparam int IW = 32;
  localparam logic [IW-1:0] NOP = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  if_id_stage_if #(.PC_DATA_WIDTH(PW), .INSTRUCTION_WIDTH(IW)) bus ();

  if_id_stage #(
    .PC_DATA_WIDTH     (PW),
    .INSTRUCTION_WIDTH (IW),
    .NOP_INSTRUCTION   (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Instruction memory contents as a pure function of the address.
  function automatic logic [IW-1:0] mem_f(input logic [PW-1:0] a);
    return {12'h0, a} ^ 32'hA5A5_0000;
  endfunction

  // Synchronous SRAM: read data appears the cycle after the address.
  always @(posedge clk) bus.inst_mem_data_in <= mem_f(bus.pc_in);

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc_out"},     32'(bus.pc_out), 32'h0);
    check({tag, " new_pc_out"}, 32'(bus.new_pc_out), 32'h0);
    check({tag, " inst"},       bus.instruction_reg_out, NOP);
    check({tag, " valid"},      32'(bus.valid_out), 32'h0);
  endtask

  typedef struct {
    logic          stall;
    logic          flush;
    logic          boot;
    logic [PW-1:0] pc_in;
    logic          exp_v;
    logic [PW-1:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic fl, input logic bt,
                     input logic [PW-1:0] pc, input logic v, input logic [PW-1:0] epc);
    vec_t r;
    r.stall = st; r.flush = fl; r.boot = bt; r.pc_in = pc;
    r.exp_v = v; r.exp_pc = epc;
    vecs.push_back(r);
  endtask

  typedef struct packed {
    logic [PW-1:0] pc;
    logic          valid;
  } slot_t;

  initial begin
    slot_t         in_flight, exp_out;
    logic [PW-1:0] fetch_pc;
    logic          st, fl, bt, kl;

    bus.stall = 1'b0; bus.flush = 1'b0; bus.boot_mode = 1'b0; bus.pc_in = '0;

    // ---- directed table -------------------------------------------------
    // Sequential stream, 3-cycle stall at pc_out=8, flush at pc_out=16,
    // flush+stall while holding, 5 boot cycles, PC wrap at 20'hFFFFC.
    add(0,0,0,20'h00000, 0, 20'h0);
    add(0,0,0,20'h00004, 1, 20'h00000);
    add(0,0,0,20'h00008, 1, 20'h00004);
    add(0,0,0,20'h0000C, 1, 20'h00008);
    for (int i = 0; i < 3; i++) add(1,0,0,20'h00010, 1, 20'h00008);
    add(0,0,0,20'h00010, 1, 20'h0000C);
    add(0,0,0,20'h00014, 1, 20'h00010);
    add(0,1,0,20'h00018, 0, 20'h0);
    add(0,0,0,20'h00100, 0, 20'h0);
    add(0,0,0,20'h00104, 1, 20'h00100);
    add(0,0,0,20'h00108, 1, 20'h00104);
    add(1,0,0,20'h0010C, 1, 20'h00104);
    add(1,1,0,20'h0010C, 0, 20'h0);
    add(0,0,0,20'h00200, 0, 20'h0);
    add(0,0,0,20'h00204, 1, 20'h00200);
    for (int i = 0; i < 5; i++) add(0,0,1,20'h00000, 0, 20'h0);
    add(0,0,0,20'h00000, 0, 20'h0);
    add(0,0,0,20'h00004, 1, 20'h00000);
    add(0,0,0,20'hFFFFC, 1, 20'h00004);
    add(0,0,0,20'h00000, 1, 20'hFFFFC);
    add(0,0,0,20'h00004, 1, 20'h00000);

    #2;
    check_reset_values("reset");
    step();
    check_reset_values("reset held");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.stall = vecs[i].stall; bus.flush = vecs[i].flush;
      bus.boot_mode = vecs[i].boot; bus.pc_in = vecs[i].pc_in;
      step();
      check($sformatf("vec%0d valid", i), 32'(bus.valid_out), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d inst", i), bus.instruction_reg_out,
            vecs[i].exp_v ? mem_f(vecs[i].exp_pc) : NOP);
      if (vecs[i].exp_v) begin
        check($sformatf("vec%0d pc_out", i), 32'(bus.pc_out), 32'(vecs[i].exp_pc));
        check($sformatf("vec%0d new_pc_out", i), 32'(bus.new_pc_out),
              32'(PW'(vecs[i].exp_pc + 20'd4)));
      end
    end

    // ---- reset asserted mid-stall --------------------------------------
    bus.flush = 1'b0; bus.boot_mode = 1'b0; bus.stall = 1'b1;
    step();
    step();
    check("pre-reset valid", 32'(bus.valid_out), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_reset_values("mid-stall reset");
    step();
    bus.stall = 1'b0; bus.pc_in = 20'h0;
    #2 rst = 1'b0;
    step();
    check("post-reset edge1 valid", 32'(bus.valid_out), 32'h0);
    bus.pc_in = 20'h4;
    step();
    check("post-reset edge2 valid", 32'(bus.valid_out), 32'h1);
    check("post-reset edge2 pc", 32'(bus.pc_out), 32'h0);
    check("post-reset edge2 inst", bus.instruction_reg_out, mem_f(20'h0));

    // ---- randomized run against the reference model --------------------
    rst = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.boot_mode = 1'b0;
    fetch_pc = 20'h0; bus.pc_in = fetch_pc;
    step();
    rst = 1'b0;
    in_flight = '{pc: '0, valid: 1'b0};
    exp_out   = '{pc: '0, valid: 1'b0};

    for (int c = 0; c < 3000; c++) begin
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 15) == 0);
      bt = ($urandom_range(0, 31) == 0);
      kl = fl || bt;
      bus.stall = st; bus.flush = fl; bus.boot_mode = bt; bus.pc_in = fetch_pc;
      step();

      // The in-flight request moves to the output on any unstalled edge;
      // a flush/boot turns whatever lands on the output into a bubble and
      // cancels the request it overlaps.
      if (!st) begin
        exp_out       = in_flight;
        exp_out.valid = in_flight.valid && !kl;
        in_flight     = '{pc: fetch_pc, valid: !kl};
      end else if (kl) begin
        exp_out         = '{pc: in_flight.pc, valid: 1'b0};
        in_flight.valid = 1'b0;
      end

      check("rand valid", 32'(bus.valid_out), 32'(exp_out.valid));
      check("rand inst", bus.instruction_reg_out, exp_out.valid ? mem_f(exp_out.pc) : NOP);
      if (exp_out.valid) begin
        check("rand pc_out", 32'(bus.pc_out), 32'(exp_out.pc));
        check("rand new_pc_out", 32'(bus.new_pc_out), 32'(PW'(exp_out.pc + 20'd4)));
      end

      // Fetch unit behaviour: redirect after a flush, advance when free.
      if (kl) begin
        if ($urandom_range(0, 3) == 0) fetch_pc = 20'hFFFF0;
        else fetch_pc = PW'($urandom) & 20'hFFFFC;
      end else if (!st) begin
        fetch_pc = fetch_pc + 20'd4;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
